// File: rtl/sar_threshold_search.sv
// Successive-approximation controller for a registered magnitude comparator.
// Walks thresh from MSB to LSB and reads back greater/lesser/equal to recover
// the comparator's unknown input. Stops early on an equal flag, and aborts
// the search if the flags at a sample point are not exactly one-hot.
module sar_threshold_search #(
   parameter int WIDTH   = 16,
   parameter int CMP_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] thresh,
   input  logic             greater,
   input  logic             lesser,
   input  logic             equal,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             exact,
   output logic             err
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
   localparam logic [2:0]    LAT = 3'(CMP_LAT);

   typedef enum logic [1:0] {IDLE, SET, WAIT, DECIDE} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    idx, idx_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [2:0]       cnt, cnt_nxt;
   logic [WIDTH-1:0] thresh_nxt, result_nxt;
   logic             busy_nxt, done_nxt, exact_nxt, err_nxt;

   // Single-bit mask for the bit currently under trial.
   logic [WIDTH-1:0] mask;
   // Accumulator with the trial bit resolved from the sampled flags.
   logic [WIDTH-1:0] acc_upd;
   // Exactly one of the three flags is set.
   logic             one_hot;

   // Decode of the current trial bit and the flag sanity check.
   always_comb begin
      mask    = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
      acc_upd = greater ? (acc | mask) : (acc & ~mask);
      one_hot = (greater & ~lesser & ~equal) |
                (~greater & lesser & ~equal) |
                (~greater & ~lesser & equal);
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= TOP;
         acc    <= '0;
         cnt    <= '0;
         thresh <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         exact  <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         thresh <= thresh_nxt;
         result <= result_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         exact  <= exact_nxt;
         err    <= err_nxt;
      end
   end

   // Next-state and output sequencing; every search ends through the same
   // path so done pulses once and busy drops on the edge that enters IDLE.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      thresh_nxt = thresh;
      result_nxt = result;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      exact_nxt  = exact;
      err_nxt    = err;

      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt   = '0;
               exact_nxt = 1'b0;
               err_nxt   = 1'b0;
               idx_nxt   = TOP;
               busy_nxt  = 1'b1;
               state_nxt = SET;
            end
         end

         SET: begin
            thresh_nxt = acc | mask;
            cnt_nxt    = LAT;
            state_nxt  = WAIT;
         end

         // Counter reaching zero on this edge moves on, so WAIT spans
         // exactly CMP_LAT cycles.
         WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt <= 3'd1) state_nxt = DECIDE;
         end

         DECIDE: begin
            if (!one_hot) begin
               err_nxt    = 1'b1;
               result_nxt = acc;
               state_nxt  = IDLE;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
            end else if (equal) begin
               exact_nxt  = 1'b1;
               result_nxt = thresh;
               state_nxt  = IDLE;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
            end else begin
               acc_nxt = acc_upd;
               if (idx == '0) begin
                  result_nxt = acc_upd;
                  state_nxt  = IDLE;
                  busy_nxt   = 1'b0;
                  done_nxt   = 1'b1;
               end else begin
                  idx_nxt   = idx - 1'b1;
                  state_nxt = SET;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sar_threshold_search.sv
// Bench for sar_threshold_search: two instances (comparator latency 1 and 3)
// each behind a behavioural registered comparator. A reference search model
// pushes expected trials and results when a start is driven; monitors pop
// and compare when the selected DUT samples a trial or pulses done.
module tb_sar_threshold_search;

   typedef struct {
      logic [15:0] res;
      logic        ex;
      logic        er;
      int          cyc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   logic        inj = 1'b0;
   logic [15:0] in_val = '0;

   logic [15:0] thr1, thr3, res1, res3, h3a, h3b;
   logic        busy1, busy3, done1, done3, ex1, ex3, er1, er3;
   logic [2:0]  fl1 = '0, fl3 = '0;

   sb_t         sbq[$];
   logic [15:0] thq[$];
   int          cyc = 0, t0 = 0, bcnt = 0;
   int          total = 0, nbad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] cmpf(logic [15:0] v, logic [15:0] t);
      return {v > t, v < t, v == t};
   endfunction

   // Comparator models: latency 1 and latency 3 from a thresh change.
   always @(posedge clk) fl1 <= cmpf(in_val, thr1);
   always @(posedge clk) begin
      h3a <= thr3;
      h3b <= h3a;
      fl3 <= cmpf(in_val, h3b);
   end

   sar_threshold_search #(.WIDTH(16), .CMP_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .thresh(thr1),
      .greater(inj ? 1'b1 : fl1[2]), .lesser(inj ? 1'b1 : fl1[1]),
      .equal(inj ? 1'b0 : fl1[0]),
      .busy(busy1), .done(done1), .result(res1), .exact(ex1), .err(er1));

   sar_threshold_search #(.WIDTH(16), .CMP_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .thresh(thr3),
      .greater(fl3[2]), .lesser(fl3[1]), .equal(fl3[0]),
      .busy(busy3), .done(done3), .result(res3), .exact(ex3), .err(er3));

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference search: trial values, final result/flags and done latency.
   function automatic void model(logic [15:0] v, int badt);
      logic [15:0] acc = '0, t;
      sb_t e;
      int  k = 0;
      bit  fin = 0;
      int  lat = sel ? 3 : 1;
      e.res = '0; e.ex = 0; e.er = 0;
      for (int i = 15; i >= 0 && !fin; i--) begin
         k++;
         t = acc | (16'h1 << i);
         thq.push_back(t);
         if (k == badt) begin
            e.er = 1; e.res = acc; fin = 1;
         end else if (v == t) begin
            e.ex = 1; e.res = t; fin = 1;
         end else if (v > t) begin
            acc = t;
         end
      end
      if (!fin) e.res = acc;
      e.cyc = k * (lat + 2);
      sbq.push_back(e);
   endfunction

   // Monitor on the selected instance, sampled mid-cycle.
   always @(negedge clk) begin
      logic [15:0] th, rs;
      logic        bz, dn, ex, er;
      int          lat;
      sb_t         e;
      th = sel ? thr3 : thr1;   rs = sel ? res3 : res1;
      bz = sel ? busy3 : busy1; dn = sel ? done3 : done1;
      ex = sel ? ex3 : ex1;     er = sel ? er3 : er1;
      lat = sel ? 3 : 1;
      if (rst_n) begin
         if (bz) begin
            bcnt++;
            if ((cyc - t0 - 1) % (lat + 2) == 0) begin
               if (thq.size() == 0) chk("trial_extra", {16'h0, th}, 32'hFFFF_FFFF);
               else chk("thresh", {16'h0, th}, {16'h0, thq.pop_front()});
            end
         end
         if (dn) begin
            if (sbq.size() == 0) chk("spurious_done", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("result", {16'h0, rs}, {16'h0, e.res});
               chk("exact", {31'h0, ex}, {31'h0, e.ex});
               chk("err", {31'h0, er}, {31'h0, e.er});
               chk("done_cyc", cyc - t0, e.cyc);
               chk("busy_cnt", bcnt, e.cyc);
               chk("busy_at_done", {31'h0, bz}, 0);
               chk("trials_left", thq.size(), 0);
               thq.delete();
            end
         end
      end
   end

   task automatic kick(logic [15:0] v, int badt);
      in_val = v;
      model(v, badt);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
      bcnt = 0;
   endtask

   task automatic run(logic [15:0] v, int badt, bit ign);
      int n, lat;
      lat = sel ? 3 : 1;
      kick(v, badt);
      n = sbq[$].cyc;
      if (badt > 0) begin
         while (cyc != t0 + badt * (lat + 2) - 1) begin
            @(posedge clk);
            #1;
         end
         inj = 1'b1;
         @(posedge clk);
         #1;
         inj = 1'b0;
      end
      for (int i = 0; i < n + 20 && sbq.size() != 0; i++) begin
         @(negedge clk);
         start = ign && (cyc - t0) > 2 && (cyc - t0) < n - 3 && ((cyc - t0) % 4 == 0);
      end
      start = 1'b0;
      if (sbq.size() != 0) begin
         chk("timeout", 0, 1);
         sbq.delete();
         thq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #12;
      chk("rst_thr1", {16'h0, thr1}, 0);
      chk("rst_res1", {16'h0, res1}, 0);
      chk("rst_flags1", {28'h0, busy1, done1, ex1, er1}, 0);
      chk("rst_thr3", {16'h0, thr3}, 0);
      chk("rst_flags3", {28'h0, busy3, done3, ex3, er3}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      sel = 1'b0;
      run(16'h1234, 0, 0);
      run(16'h0000, 0, 0);
      run(16'h8000, 0, 0);
      run(16'hFFFF, 0, 0);
      run(16'hA000, 3, 0);
      run(16'h0005, 0, 0);
      run(16'h3C5A, 0, 1);

      // Reset in the middle of a search aborts without a done pulse.
      kick(16'h4321, 0);
      while (cyc != t0 + 20) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("abort_thr", {16'h0, thr1}, 0);
      chk("abort_res", {16'h0, res1}, 0);
      chk("abort_flags", {28'h0, busy1, done1, ex1, er1}, 0);
      sbq.delete();
      thq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run(16'h00FF, 0, 0);

      sel = 1'b1;
      repeat (2) @(negedge clk);
      run(16'hA5A5, 0, 1);
      run(16'h0001, 0, 0);

      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end

endmodule
